// File: rtl/pkg_alu.sv
// Shared definitions for the operand-entry stage, the comparator and the ALU.
package pkg_alu;

  // Default magnitude width of each operand.
  localparam int LARGURA_PADRAO = 4;

  // Sequencer state codes, also driven onto the board LEDs.
  typedef enum logic [1:0] {
    ESPERA_A = 2'd0,
    ESPERA_B = 2'd1,
    PRONTO   = 2'd2
  } estado_t;

endpackage

// File: rtl/debounce_botao.sv
// Load push-button conditioning: 2-flop synchronizer, level debounce filter
// and rising-edge detector producing a single-cycle pulse per accepted press.
module debounce_botao #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  output logic pulso
);

  // The filtered level toggles on the cycle the count would reach DEBOUNCE.
  localparam logic [7:0] LIMITE = 8'(DEBOUNCE - 1);

  logic       sync_1;
  logic       sync_2;
  logic       filtrado;
  logic       filtrado_d;
  logic [7:0] contador;

  // Synchronize the raw button, then accept a level change only after
  // DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      filtrado   <= 1'b0;
      filtrado_d <= 1'b0;
      contador   <= 8'd0;
    end else begin
      sync_1     <= botao;
      sync_2     <= sync_1;
      filtrado_d <= filtrado;
      if (sync_2 != filtrado) begin
        if (contador == LIMITE) begin
          filtrado <= ~filtrado;
          contador <= 8'd0;
        end else begin
          contador <= contador + 8'd1;
        end
      end else begin
        contador <= 8'd0;
      end
    end
  end

  // One pulse per accepted press; release is ignored.
  assign pulso = filtrado & ~filtrado_d;

endmodule

// File: rtl/entrada_operandos.sv
// Operand-entry stage: captures operand A then operand B from shared
// switches on each debounced load press and presents them with a valid flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ESPERA_A | waiting for the press that captures A
//   ESPERA_B | A captured, waiting for the press that captures B
//   PRONTO   | A and B form a complete pair (valido=1)
//   code 3   | illegal, returns to ESPERA_A on the next edge
module entrada_operandos
  import pkg_alu::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] chaves,
  input  logic               sinal_chave,
  input  logic               carregar,
  input  logic               limpar,
  output logic [LARGURA-1:0] a,
  output logic               sa,
  output logic [LARGURA-1:0] b,
  output logic               sb,
  output logic               valido,
  output logic [1:0]         estado
);

  estado_t estado_atual;
  estado_t estado_prox;
  logic    pulso;
  logic    captura_a;
  logic    captura_b;

  debounce_botao #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .botao (carregar),
    .pulso (pulso)
  );

  assign estado = estado_atual;

  // State register; limpar acts like reset on the sequencer only.
  always_ff @(posedge clk) begin
    if (rst || limpar) begin
      estado_atual <= ESPERA_A;
    end else begin
      estado_atual <= estado_prox;
    end
  end

  // Next-state: advance on each load pulse, recover from the illegal code.
  always_comb begin
    estado_prox = estado_atual;
    case (estado_atual)
      ESPERA_A: if (pulso) estado_prox = ESPERA_B;
      ESPERA_B: if (pulso) estado_prox = PRONTO;
      PRONTO:   if (pulso) estado_prox = ESPERA_B;
      default:             estado_prox = ESPERA_A;
    endcase
  end

  // Capture strobes: a new pair always starts with A.
  always_comb begin
    captura_a = 1'b0;
    captura_b = 1'b0;
    case (estado_atual)
      ESPERA_A: captura_a = pulso;
      ESPERA_B: captura_b = pulso;
      PRONTO:   captura_a = pulso;
      default: begin
        captura_a = 1'b0;
        captura_b = 1'b0;
      end
    endcase
  end

  // Operand registers; values are stored as-is, including negative zero.
  always_ff @(posedge clk) begin
    if (rst || limpar) begin
      a      <= '0;
      sa     <= 1'b0;
      b      <= '0;
      sb     <= 1'b0;
      valido <= 1'b0;
    end else begin
      if (captura_a) begin
        a      <= chaves;
        sa     <= sinal_chave;
        valido <= 1'b0;
      end
      if (captura_b) begin
        b      <= chaves;
        sb     <= sinal_chave;
        valido <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_entrada_operandos.sv
// Scoreboard bench for entrada_operandos: stimulus pushes the expected output
// vector and the cycle it must appear on; a monitor pops on every output change.
module tb_entrada_operandos;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] chaves;
  logic       sinal_chave;
  logic       carregar;
  logic       limpar;
  logic [3:0] a;
  logic       sa;
  logic [3:0] b;
  logic       sb;
  logic       valido;
  logic [1:0] estado;

  entrada_operandos #(
    .LARGURA  (4),
    .DEBOUNCE (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .chaves      (chaves),
    .sinal_chave (sinal_chave),
    .carregar    (carregar),
    .limpar      (limpar),
    .a           (a),
    .sa          (sa),
    .b           (b),
    .sb          (sb),
    .valido      (valido),
    .estado      (estado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] v;
    logic [31:0] cyc;
  } esperado_t;

  esperado_t   fila[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [12:0] prev;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] vetor(input logic [3:0] va, input logic vsa,
                                        input logic [3:0] vb, input logic vsb,
                                        input logic vv, input logic [1:0] ve);
    return {va, vsa, vb, vsb, vv, ve};
  endfunction

  wire [12:0] atual = {a, sa, b, sb, valido, estado};

  // Monitor: every output change must match the next expected entry and cycle.
  always @(negedge clk) begin
    if (mon_en && (atual !== prev)) begin
      if (fila.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=%h", cyc, atual, prev);
      end else begin
        esperado_t e;
        e = fila.pop_front();
        n_cmp++;
        if (atual !== e.v) begin
          n_err++;
          $display("FAIL outputs cyc=%0d got a=%0d sa=%0d b=%0d sb=%0d v=%0d e=%0d required=%h",
                   cyc, a, sa, b, sb, valido, estado, e.v);
        end
        n_cmp++;
        if (cyc != e.cyc) begin
          n_err++;
          $display("FAIL latency got cyc=%0d required cyc=%0d", cyc, e.cyc);
        end
      end
    end
    if (mon_en) prev = atual;
  end

  task automatic pressionar(input logic [3:0] mag, input logic s, input int hold,
                            input logic [12:0] exp_v);
    @(negedge clk);
    chaves      = mag;
    sinal_chave = s;
    carregar    = 1'b1;
    fila.push_back({exp_v, cyc + 32'd7});
    repeat (hold) @(negedge clk);
    carregar = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulsar_limpar();
    @(negedge clk);
    limpar = 1'b1;
    fila.push_back({13'd0, cyc + 32'd1});
    @(negedge clk);
    limpar = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; chaves = 4'd0; sinal_chave = 1'b0; carregar = 1'b0; limpar = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (atual !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state got=%h required=0", atual);
    end
    prev   = atual;
    mon_en = 1'b1;

    // Idle: nothing may change.
    repeat (20) @(negedge clk);

    // Capture A then B.
    pressionar(4'd5, 1'b1, 10, vetor(4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 2'd1));
    pressionar(4'd3, 1'b0, 10, vetor(4'd5, 1'b1, 4'd3, 1'b0, 1'b1, 2'd2));

    // Recapture A from PRONTO, B retained.
    pressionar(4'd9, 1'b0, 10, vetor(4'd9, 1'b0, 4'd3, 1'b0, 1'b0, 2'd1));

    // Back to ESPERA_A, then a 3-cycle glitch that must be ignored.
    pulsar_limpar();
    @(negedge clk);
    chaves = 4'd11; sinal_chave = 1'b1; carregar = 1'b1;
    repeat (3) @(negedge clk);
    carregar = 1'b0;
    repeat (15) @(negedge clk);

    // Capture A, then limpar on the very edge the B capture would happen.
    pressionar(4'd7, 1'b0, 10, vetor(4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 2'd1));
    @(negedge clk);
    chaves = 4'd6; sinal_chave = 1'b0; carregar = 1'b1;
    fila.push_back({13'd0, cyc + 32'd7});
    repeat (6) @(negedge clk);
    limpar = 1'b1;
    @(negedge clk);
    limpar = 1'b0;
    repeat (20) @(negedge clk);
    carregar = 1'b0;
    repeat (12) @(negedge clk);
    pressionar(4'd2, 1'b1, 10, vetor(4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 2'd1));

    // Negative zero for both operands.
    pulsar_limpar();
    pressionar(4'd0, 1'b1, 10, vetor(4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd1));
    pressionar(4'd0, 1'b1, 10, vetor(4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 2'd2));

    repeat (5) @(negedge clk);
    n_cmp++;
    if (fila.size() != 0) begin
      n_err++;
      $display("FAIL missing_outputs got pending=%0d required=0", fila.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/entrada_operandos.md
Name: entrada_operandos

Overview:
- Upstream operand-entry stage for the sign-magnitude comparator and the ALU datapath.
- Takes a single shared set of board switches (magnitude plus sign) and a raw load push-button.
- A 3-state sequencer captures operand A, then operand B.
- Presents both as stable registered values, with a valid flag, to the comparator inputs a/sa/b/sb.

Parameters:
- LARGURA, 4, magnitude width of each operand in bits.
- DEBOUNCE, 4, number of consecutive stable synchronized samples required to accept a button level change; range 1..255 (board build overrides with a large value).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- chaves  input  LARGURA  magnitude switches, shared by A and B
- sinal_chave  input  1  sign switch (1 = negative)
- carregar  input  1  raw asynchronous load button (1 = pressed)
- limpar  input  1  synchronous clear, active-high, already synchronous to clk
- a  output  LARGURA  captured magnitude A
- sa  output  1  captured sign A
- b  output  LARGURA  captured magnitude B
- sb  output  1  captured sign B
- valido  output  1  high while A and B form a complete pair
- estado  output  2  current state code for board LEDs

Behaviour:
- Reset (rst=1 at a clk edge):
  - a=0, sa=0, b=0, sb=0, valido=0, estado=ESPERA_A.
  - Synchronizer flops, filtered level and its delayed copy are set to 0.
  - Debounce counter is set to 0.
- Reset mid-entry discards any partial capture.
- Synchronizer: 2-flop chain on carregar. chaves and sinal_chave are quasi-static and are not synchronized; they must be stable for at least 1 cycle around the capture edge.
- Debounce:
  - An 8-bit counter increments each cycle the synchronized sample differs from the filtered level.
  - When the count reaches DEBOUNCE, the filtered level toggles and the counter is set to 0.
  - Any cycle where sample equals filtered level resets the counter to 0. A glitch shorter than DEBOUNCE cycles is therefore ignored.
- Load pulse: pulso = filtered & ~filtered_d, combinational, high for exactly 1 cycle per accepted press. Release generates no pulse.
- Latency: carregar high sampled at edge k and held → filtered=1 after edge k+1+DEBOUNCE → capture at edge k+2+DEBOUNCE. With defaults, outputs are updated after edge k+6.
- FSM, with estado codes ESPERA_A=0, ESPERA_B=1, PRONTO=2 (code 3 is illegal and recovers to ESPERA_A on the next edge):
  - ESPERA_A, pulso: a←chaves, sa←sinal_chave → ESPERA_B.
  - ESPERA_B, pulso: b←chaves, sb←sinal_chave, valido←1 → PRONTO.
  - PRONTO, pulso: a←chaves, sa←sinal_chave, valido←0 → ESPERA_B. b and sb keep their old values until recaptured.
  - No pulso: hold all state.
- Priority at an edge: rst > limpar > pulso.
  - limpar has the same effect as reset on all outputs and FSM.
  - limpar does not reset the debounce path, so a press held through limpar produces no new pulse.
- Captured values are stored unmodified. Negative zero (magnitude 0, sign 1) is passed through, because the comparator normalizes it.
- All outputs are registered. a, sa, b and sb change only on capture, reset or limpar.

Decomposition:
- Shared package (pkg_alu) holds:
  - the estado encoding constants ESPERA_A, ESPERA_B, PRONTO;
  - the default LARGURA constant used by the comparator and ALU.
- One natural sub-module, debounce_botao. It contains the 2-flop synchronizer, the debounce counter and the edge detector, takes parameter DEBOUNCE, and outputs pulso.
- The FSM and operand registers stay in entrada_operandos.

Test Plan:
1. Reset then idle → all outputs 0, estado=0 for 20 cycles with carregar=0.
2. chaves=5, sinal_chave=1, press carregar held 10 cycles; then chaves=3, sinal_chave=0, press again:
   - first press: a=5, sa=1, estado=1, exactly 6 cycles after the press is first sampled;
   - second press: b=3, sb=0, valido=1, estado=2.
3. carregar glitch high for 3 cycles (DEBOUNCE=4) in ESPERA_A → no capture; estado stays 0, a stays 0.
4. In PRONTO (a=5, b=3), chaves=9, sinal_chave=0, press:
   - a=9, sa=0, valido=0, estado=1;
   - b=3 is retained.
5. limpar pulsed 1 cycle in ESPERA_B while carregar is held high → all outputs 0, estado=0; no capture occurs until carregar is released and pressed again.
6. chaves=0, sinal_chave=1 captured for both A and B → a=0, sa=1, b=0, sb=1, valido=1; the connected comparator then reports igual=1.
